// File: rtl/nms_pkg.sv
// Shared types and constants for the NMS window feeder and the NMS datapath.
package nms_pkg;

    localparam int PIX_W   = 8;
    localparam int SCORE_W = 8;
    localparam int ADJ_W   = 8 * SCORE_W;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0]   pixel;
        logic [SCORE_W-1:0] score;
    } line_entry_t;

    // Byte-lane index of each neighbour inside adj_score (lane k = bits [8k+7:8k]).
    localparam int ADJ_NW = 7;
    localparam int ADJ_N  = 6;
    localparam int ADJ_NE = 5;
    localparam int ADJ_W_ = 4;
    localparam int ADJ_E  = 3;
    localparam int ADJ_SW = 2;
    localparam int ADJ_S  = 1;
    localparam int ADJ_SE = 0;

    function automatic logic [SCORE_W-1:0] mask_score(input logic [SCORE_W-1:0] s,
                                                      input logic m);
        return m ? '0 : s;
    endfunction

endpackage

// File: rtl/nms_line_buffer.sv
// Depth-DEPTH circular delay line of {pixel, score} entries: the read returns the
// entry written DEPTH advances ago, and the same slot is overwritten on the advance.
module nms_line_buffer
    import nms_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_adv,
    input  line_entry_t i_wr_data,
    output line_entry_t o_rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    line_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_ptr;

    assign o_rd_data = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_mem[r_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + AW'(1);
        end
    end

endmodule

// File: rtl/nms_window_feeder.sv
// Builds one 3x3 score window plus centre pixel per raster input for the NMS stage.
// Optional macro NMS_FEEDER_BORDER_SUPPRESS_EN zeroes ref_score on image-border windows.
module nms_window_feeder
    import nms_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pixel,
    input  logic [SCORE_W-1:0] in_score,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   ref_pixel,
    output logic [SCORE_W-1:0] ref_score,
    output logic [ADJ_W-1:0]   adj_score,
    output logic [1:0]         o_dbg_state
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    state_e             r_state, w_state_nxt;
    logic [XW-1:0]      r_in_x, r_out_x;
    logic [YW-1:0]      r_in_y, r_out_y;
    logic               w_in_fire, w_slot_free, w_adv, w_load;
    logic               w_in_last, w_out_last;
    logic               w_mask_l, w_mask_r, w_mask_t, w_mask_b;
    line_entry_t        w_new_bot, w_new_mid, w_new_top;
    logic [PIX_W-1:0]   w_unused_top_pixel;
    line_entry_t        r_a_mid;
    logic [SCORE_W-1:0] r_a_top, r_a_bot, r_b_top, r_b_mid, r_b_bot;
    logic [SCORE_W-1:0] w_ref_score;
    logic [ADJ_W-1:0]   w_adj;

    assign w_slot_free = !out_valid || out_ready;
    assign in_ready    = (r_state == FILL) || ((r_state == STREAM) && w_slot_free);
    assign w_in_fire   = in_valid && in_ready;
    assign w_adv       = (r_state == FLUSH) ? w_slot_free : w_in_fire;
    assign w_load      = w_adv && (r_state != FILL);
    assign w_in_last   = (r_in_x == X_LAST) && (r_in_y == Y_LAST);
    assign w_out_last  = (r_out_x == X_LAST) && (r_out_y == Y_LAST);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_in_fire && (r_in_x == '0) && (r_in_y == YW'(1))) w_state_nxt = STREAM;
            STREAM:  if (w_in_fire && w_in_last) w_state_nxt = FLUSH;
            FLUSH:   if (w_adv && w_out_last) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // Input counters track the raster index being accepted, output counters the
    // centre of the next window; both wrap to zero at the end of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_x  <= '0;
            r_in_y  <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
        end else begin
            if (w_in_fire) begin
                if (r_in_x == X_LAST) begin
                    r_in_x <= '0;
                    r_in_y <= (r_in_y == Y_LAST) ? '0 : r_in_y + YW'(1);
                end else begin
                    r_in_x <= r_in_x + XW'(1);
                end
            end
            if (w_load) begin
                if (r_out_x == X_LAST) begin
                    r_out_x <= '0;
                    r_out_y <= (r_out_y == Y_LAST) ? '0 : r_out_y + YW'(1);
                end else begin
                    r_out_x <= r_out_x + XW'(1);
                end
            end
        end
    end

    // FLUSH advances the pipeline with zero padding in place of real input.
    assign w_new_bot = (r_state == FLUSH) ? '0 : line_entry_t'{pixel: in_pixel, score: in_score};

    nms_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_mid (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_adv     (w_adv),
        .i_wr_data (w_new_bot),
        .o_rd_data (w_new_mid)
    );

    nms_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_top (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_adv     (w_adv),
        .i_wr_data (w_new_mid),
        .o_rd_data (w_new_top)
    );

    // Only the centre pixel leaves the block; the upper row's pixel is dropped.
    assign w_unused_top_pixel = w_new_top.pixel;

    // Column a holds raster index i-1 (centre column), column b holds i-2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_top <= '0;
            r_a_mid <= '0;
            r_a_bot <= '0;
            r_b_top <= '0;
            r_b_mid <= '0;
            r_b_bot <= '0;
        end else if (w_adv) begin
            r_b_top <= r_a_top;
            r_b_mid <= r_a_mid.score;
            r_b_bot <= r_a_bot;
            r_a_top <= w_new_top.score;
            r_a_mid <= w_new_mid;
            r_a_bot <= w_new_bot.score;
        end
    end

    assign w_mask_l = (r_out_x == '0);
    assign w_mask_r = (r_out_x == X_LAST);
    assign w_mask_t = (r_out_y == '0);
    assign w_mask_b = (r_out_y == Y_LAST);

    always_comb begin
        w_adj = '0;
        w_adj[ADJ_NW*8 +: 8] = mask_score(r_b_top,         w_mask_l || w_mask_t);
        w_adj[ADJ_N*8  +: 8] = mask_score(r_a_top,         w_mask_t);
        w_adj[ADJ_NE*8 +: 8] = mask_score(w_new_top.score, w_mask_r || w_mask_t);
        w_adj[ADJ_W_*8 +: 8] = mask_score(r_b_mid,         w_mask_l);
        w_adj[ADJ_E*8  +: 8] = mask_score(w_new_mid.score, w_mask_r);
        w_adj[ADJ_SW*8 +: 8] = mask_score(r_b_bot,         w_mask_l || w_mask_b);
        w_adj[ADJ_S*8  +: 8] = mask_score(r_a_bot,         w_mask_b);
        w_adj[ADJ_SE*8 +: 8] = mask_score(w_new_bot.score, w_mask_r || w_mask_b);
    end

`ifdef NMS_FEEDER_BORDER_SUPPRESS_EN
    assign w_ref_score = mask_score(r_a_mid.score, w_mask_l || w_mask_r || w_mask_t || w_mask_b);
`else
    assign w_ref_score = r_a_mid.score;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ref_pixel <= '0;
            ref_score <= '0;
            adj_score <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            ref_pixel <= r_a_mid.pixel;
            ref_score <= w_ref_score;
            adj_score <= w_adj;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nms_window_feeder.sv
// Directed bench for nms_window_feeder at W=4, H=3 (honours NMS_FEEDER_BORDER_SUPPRESS_EN).
module tb_nms_window_feeder;
    import nms_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = '0;
    logic [7:0]  in_score = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  ref_pixel;
    logic [7:0]  ref_score;
    logic [63:0] adj_score;
    logic [1:0]  o_dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [79:0] exp_q[$];
    logic [79:0] got [64];
    int          got_n = 0;
    bit          sb_en = 1'b1;
    bit          ready_mode = 1'b0;
    bit          ready_force = 1'b1;

    nms_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .in_score    (in_score),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ref_pixel   (ref_pixel),
        .ref_score   (ref_score),
        .adj_score   (adj_score),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Downstream ready: forced level or random, applied 2 time units after each edge.
    always @(posedge clk) begin
        #2;
        out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Output monitor: records every window that will transfer on the next edge.
    always @(negedge clk) begin
        if (rst_n && sb_en && out_valid && out_ready) begin
            if (got_n < 64) got[got_n] = {ref_pixel, ref_score, adj_score};
            got_n = got_n + 1;
        end
    end

    // Golden model
    function automatic logic [7:0] sc(input int base, input int xx, input int yy);
        if (xx < 0 || xx >= W || yy < 0 || yy >= H) return 8'h00;
        return 8'(base + yy * W + xx + 1);
    endfunction

    function automatic logic [79:0] model(input int base, input int j);
        int x, y;
        logic [7:0] rs;
        x  = j % W;
        y  = j / W;
        rs = sc(base, x, y);
`ifdef NMS_FEEDER_BORDER_SUPPRESS_EN
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) rs = 8'h00;
`endif
        return {8'(base + j), rs,
                sc(base, x - 1, y - 1), sc(base, x, y - 1), sc(base, x + 1, y - 1),
                sc(base, x - 1, y),                         sc(base, x + 1, y),
                sc(base, x - 1, y + 1), sc(base, x, y + 1), sc(base, x + 1, y + 1)};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic send_pix(input logic [7:0] p, input logic [7:0] s);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_pixel = p;
        in_score = s;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
        end
        #1;
        in_valid = 1'b0;
        check("input_accepted", 80'(done), 80'd1);
    endtask

    task automatic idle_gap(input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int i = 0; i < N; i++) begin
            idle_gap(gaps);
            send_pix(8'(base + i), 8'(base + i + 1));
        end
    endtask

    task automatic push_frame(input int base);
        for (int j = 0; j < N; j++) exp_q.push_back(model(base, j));
    endtask

    task automatic drain_and_compare(input int start, input int nwin);
        for (int c = 0; c < 2000 && got_n < start + nwin; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("window_count", 80'(got_n), 80'(start + nwin));
        for (int k = 0; k < nwin; k++) begin
            if (exp_q.size() > 0 && start + k < 64) begin
                check($sformatf("window_%0d", start + k), got[start + k], exp_q.pop_front());
            end
        end
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  80'(in_ready),    80'd1);
        check({tag, "_out_valid"}, 80'(out_valid),   80'd0);
        check({tag, "_ref_pixel"}, 80'(ref_pixel),   80'd0);
        check({tag, "_ref_score"}, 80'(ref_score),   80'd0);
        check({tag, "_adj_score"}, 80'(adj_score),   80'd0);
        check({tag, "_state"},     80'(o_dbg_state), 80'(FILL));
    endtask

    // Directed sequence
    initial begin
        int s;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: base 0, out_ready high, FILL/STREAM boundary timing.
        s = got_n;
        push_frame(0);
        for (int i = 0; i < N; i++) begin
            send_pix(8'(i), 8'(i + 1));
            if (i == W) begin
                check("fill_no_output", 80'(out_valid),   80'd0);
                check("enter_stream",   80'(o_dbg_state), 80'(STREAM));
            end
            if (i == W + 1) check("first_window_valid", 80'(out_valid), 80'd1);
        end
        drain_and_compare(s, N);
        check("frame_end_state",     80'(o_dbg_state), 80'(FILL));
        check("frame_end_in_ready",  80'(in_ready),    80'd1);
        check("frame_end_out_valid", 80'(out_valid),   80'd0);
        check("j5_ref_score", 80'(got[s + 5][71:64]), 80'h06);
        check("j5_adj",       80'(got[s + 5][63:0]),  80'h0102_0305_0709_0A0B);
        check("j0_adj",       80'(got[s][63:0]),      80'h0000_0000_0200_0506);
`ifdef NMS_FEEDER_BORDER_SUPPRESS_EN
        check("j0_ref_score", 80'(got[s][71:64]),     80'h00);
`else
        check("j0_ref_score", 80'(got[s][71:64]),     80'h01);
`endif
        check("j11_adj",      80'(got[s + 11][63:0]), 80'h0708_000B_0000_0000);

        // Frame 2: backpressure for 5 cycles while window 1 is held.
        s = got_n;
        push_frame(8'h20);
        for (int i = 0; i < 7; i++) send_pix(8'(8'h20 + i), 8'(8'h21 + i));
        ready_force = 1'b0;
        in_valid    = 1'b1;
        in_pixel    = 8'h27;
        in_score    = 8'h28;
        repeat (5) begin
            @(posedge clk);
            #3;
            check("hold_in_ready",  80'(in_ready),  80'd0);
            check("hold_out_valid", 80'(out_valid), 80'd1);
            check("hold_window", {ref_pixel, ref_score, adj_score}, model(8'h20, 1));
        end
        ready_force = 1'b1;
        for (int i = 7; i < N; i++) send_pix(8'(8'h20 + i), 8'(8'h21 + i));
        drain_and_compare(s, N);

        // Aborted frame: reset after input 7, then a clean frame.
        sb_en = 1'b0;
        for (int i = 0; i < 8; i++) send_pix(8'(8'h40 + i), 8'(8'h41 + i));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("midframe_reset");
        rst_n = 1'b1;
        sb_en = 1'b1;
        s = got_n;
        push_frame(8'h60);
        send_frame(8'h60, 1'b1);
        drain_and_compare(s, N);

        // Two back-to-back frames with random in_valid gaps and out_ready.
        s = got_n;
        push_frame(8'h80);
        push_frame(8'hA0);
        ready_mode = 1'b1;
        send_frame(8'h80, 1'b1);
        send_frame(8'hA0, 1'b1);
        ready_mode = 1'b0;
        drain_and_compare(s, 2 * N);
        check("final_state", 80'(o_dbg_state), 80'(FILL));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
